uart_word_rx: RTL and testbench

UART_WORD_RX -- requirements
Module: uart_word_rx

---
 rtl/uart_word_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_word_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// UART receiver that packs NUM_WORDS consecutive frames (first frame = LSBs) into one W_OUT-bit word.
// Optional macro UART_WORD_RX_FRAME_ERR_EN adds stop-bit checking and the m_frame_err pulse.
module uart_word_rx #(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    output logic             m_valid,
    output logic [W_OUT-1:0] m_data
`ifdef UART_WORD_RX_FRAME_ERR_EN
    ,
    output logic             m_frame_err
`endif
);

    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W     = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                   state_q, state_d;
    logic                     rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BITS_PER_WORD-1:0] frame_q, frame_d;
    logic [W_OUT-1:0]         word_q, word_d;
    logic [W_OUT-1:0]         data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     accept;
`ifdef UART_WORD_RX_FRAME_ERR_EN
    logic                     err_q, err_d;
    logic                     wait_q, wait_d;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values;
        // reset is synchronous and clears the word buffers too, so no partial word survives it.
        if (rstn) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            word_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
`ifdef UART_WORD_RX_FRAME_ERR_EN
            err_q     <= 1'b0;
            wait_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            word_q    <= word_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
`ifdef UART_WORD_RX_FRAME_ERR_EN
            err_q     <= err_d;
            wait_q    <= wait_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = 1'b0;
        accept  = 1'b0;
`ifdef UART_WORD_RX_FRAME_ERR_EN
        err_d   = 1'b0;
        wait_d  = wait_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_WORD_RX_FRAME_ERR_EN
                if (wait_q) begin
                    if (rx_s_q) wait_d = 1'b0;
                end else
`endif
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    frame_d = frame_q >> 1;
                    frame_d[BITS_PER_WORD-1] = rx_s_q;
                    if (bit_q == BIT_LAST) state_d = STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef UART_WORD_RX_FRAME_ERR_EN
                    if (!rx_s_q) begin
                        err_d  = 1'b1;
                        wait_d = 1'b1;
                        idx_d  = '0;
                    end else
`endif
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accepted frames go to a private buffer; m_data only changes once the word is whole.
        if (accept) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (idx_q == IDX_W'(k)) word_d[k*BITS_PER_WORD +: BITS_PER_WORD] = frame_q;
            end
            if (idx_q == IDX_LAST) begin
                data_d  = word_d;
                valid_d = 1'b1;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
`ifdef UART_WORD_RX_FRAME_ERR_EN
    assign m_frame_err = err_q;
`endif

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx (default parameters); a scoreboard holds expected words and arrival cycles.
// Adapts to UART_WORD_RX_FRAME_ERR_EN being defined or not.
module tb_uart_word_rx;

    localparam int CPP       = 16;
    localparam int VALID_LAT = 155;  // posedges from start-bit drive to the cycle m_valid is high

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        rx = 1'b1;
    logic        m_valid;
    logic [15:0] m_data;
`ifdef UART_WORD_RX_FRAME_ERR_EN
    logic        m_frame_err;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stab_err = 0;
    int err_cnt = 0;
    logic [15:0] last_data = '0;

    typedef struct {
        logic [15:0] data;
        int          at_cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0]  f0;
        logic [7:0]  f1;
        int          gap0;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[4];

    uart_word_rx #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .W_OUT(16)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rx      (rx),
        .m_valid (m_valid),
        .m_data  (m_data)
`ifdef UART_WORD_RX_FRAME_ERR_EN
        ,
        .m_frame_err (m_frame_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every m_valid must match the oldest expectation, in data and cycle.
    always @(negedge clk) begin
        if (rstn) begin
            last_data = '0;
        end else if (m_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'd0, m_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word_data", {16'd0, m_data}, {16'd0, e.data});
                check("valid_cycle", cyc, e.at_cyc);
            end
            last_data = m_data;
        end else if (m_data !== last_data) begin
            stab_err++;
        end
`ifdef UART_WORD_RX_FRAME_ERR_EN
        if (m_frame_err === 1'b1) err_cnt++;
`endif
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap_bits);
        rx = 1'b0;
        wait_cycles(CPP);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPP);
        end
        rx = stop_bit;
        wait_cycles(CPP);
        rx = 1'b1;
        wait_cycles(CPP * gap_bits);
    endtask

    task automatic send_word(input logic [7:0] f0, input logic [7:0] f1, input int gap0,
                             input logic [15:0] exp);
        exp_t e;
        send_frame(f0, 1'b1, gap0);
        e.data   = exp;
        e.at_cyc = cyc + VALID_LAT;
        sb.push_back(e);
        send_frame(f1, 1'b1, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, sb.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{f0: 8'h34, f1: 8'h12, gap0: 1, exp: 16'h1234};
        vecs[1] = '{f0: 8'hA5, f1: 8'h5A, gap0: 0, exp: 16'h5AA5};
        vecs[2] = '{f0: 8'h00, f1: 8'hFF, gap0: 1, exp: 16'hFF00};
        vecs[3] = '{f0: 8'hFF, f1: 8'h00, gap0: 0, exp: 16'h00FF};

        // Reset state
        wait_cycles(3);
        check("reset_valid", {31'd0, m_valid}, 32'd0);
        check("reset_data", {16'd0, m_data}, 32'd0);
`ifdef UART_WORD_RX_FRAME_ERR_EN
        check("reset_frame_err", {31'd0, m_frame_err}, 32'd0);
`endif
        rstn = 1'b0;
        wait_cycles(4);

        // Table: two-frame words, with one idle bit or zero gap between frames
        for (int v = 0; v < 4; v++) begin
            send_word(vecs[v].f0, vecs[v].f1, vecs[v].gap0, vecs[v].exp);
            drain($sformatf("drain_vec%0d", v));
        end

        // Short low glitch: false start, nothing stored, next word still starts at frame 0
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(40);
        check("glitch_hold", {16'd0, m_data}, 32'h00FF);
        send_word(8'h34, 8'h12, 1, 16'h1234);
        drain("drain_glitch");

        // Reset after a partial word discards it
        send_frame(8'h77, 1'b1, 1);
        rstn = 1'b1;
        wait_cycles(1);
        rstn = 1'b0;
        check("reset_clears_data", {16'd0, m_data}, 32'd0);
        wait_cycles(4);
        send_word(8'hBE, 8'hEF, 1, 16'hEFBE);
        drain("drain_reset");

        // Stop bit forced low on the second frame
        send_frame(8'h11, 1'b1, 1);
`ifdef UART_WORD_RX_FRAME_ERR_EN
        send_frame(8'h22, 1'b0, 2);
        check("frame_err_pulses", err_cnt, 1);
        check("frame_err_data_hold", {16'd0, m_data}, 32'hEFBE);
`else
        begin
            exp_t e;
            e.data   = 16'h2211;
            e.at_cyc = cyc + VALID_LAT;
            sb.push_back(e);
        end
        send_frame(8'h22, 1'b0, 2);
        drain("drain_no_stop_check");
`endif
        send_word(8'h33, 8'h44, 1, 16'h4433);
        drain("drain_after_err");

        wait_cycles(20);
        check("data_stability", stab_err, 0);
`ifdef UART_WORD_RX_FRAME_ERR_EN
        check("frame_err_total", err_cnt, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
